// File: rtl/if_id_pkg.sv
// ---------------------------------------------------------------------------
// if_id_pkg -- shared pipeline constants for the IF/ID stage.
//   IF_ID_NOP_WORD : default instruction word loaded on flush or reset
//   RS_* / RT_*    : bit positions of the rs and rt fields in an instruction
//   STALL_CNT_W    : width of the optional stall-cycle counter
// ---------------------------------------------------------------------------
package if_id_pkg;

  localparam logic [31:0] IF_ID_NOP_WORD = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/if_id_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect -- purely combinational load-use hazard detection.
// Ports:
//   valid          in   IF/ID holds a live instruction
//   rs, rt         in   source register fields of the instruction in IF/ID
//   id_ex_mem_read in   instruction in ID/EX is a load
//   id_ex_rt       in   destination register of the instruction in ID/EX
//   hazard         out  decode must wait one cycle for the load result
// ---------------------------------------------------------------------------
module hazard_detect (
  input  logic       valid,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  output logic       hazard
);

  // Register 0 is hard-wired to zero, so a load "into" it never creates a
  // dependency; an empty IF/ID slot never depends on anything.
  assign hazard = valid & id_ex_mem_read & (id_ex_rt != 5'd0) &
                  ((id_ex_rt == rs) | (id_ex_rt == rt));

endmodule

// File: rtl/if_id.sv
// ---------------------------------------------------------------------------
// if_id -- IF/ID pipeline register with load-use stall and branch flush.
// Optional feature macro: IF_ID_STALL_CNT_EN (adds the StallCount port and a
// saturating stall-cycle counter).
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   PCResult, Instr PC+4 and instruction word from fetch
//   IdEx_MemRead    instruction in ID/EX is a load
//   IdEx_Rt         destination register of the instruction in ID/EX
//   Branch_taken    redirect from branch resolution; flushes IF/ID
//   PCResult_1      registered PC+4 to decode
//   Instr_1         registered instruction to decode
//   Valid_1         IF/ID holds a live instruction
//   PCWrite         PC register enable for fetch
//   Bubble          decode zeroes all ID/EX control inputs when high
//   StallCount      stall-cycle counter (only with IF_ID_STALL_CNT_EN)
//
// Flow control: PCWrite acts as the "ready" back to fetch and Valid_1 as the
// "valid" forward to decode. A fetched word is consumed on every edge where
// PCWrite=1; when PCWrite=0 fetch must present the same word again. A flush
// overrides a stall: the slot empties and fetch proceeds from the new PC.
// ---------------------------------------------------------------------------
module if_id
  import if_id_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = IF_ID_NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            PCResult,
  input  logic [31:0]            Instr,
  input  logic                   IdEx_MemRead,
  input  logic [4:0]             IdEx_Rt,
  input  logic                   Branch_taken,
  output logic [31:0]            PCResult_1,
  output logic [31:0]            Instr_1,
  output logic                   Valid_1,
  output logic                   PCWrite,
`ifdef IF_ID_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] StallCount,
`endif
  output logic                   Bubble
);

  logic hazard;
  logic stall;

  hazard_detect u_hazard_detect (
    .valid          (Valid_1),
    .rs             (Instr_1[RS_MSB:RS_LSB]),
    .rt             (Instr_1[RT_MSB:RT_LSB]),
    .id_ex_mem_read (IdEx_MemRead),
    .id_ex_rt       (IdEx_Rt),
    .hazard         (hazard)
  );

  // A flush wins over a stall, so only a hazard without a redirect holds.
  assign stall   = hazard & ~Branch_taken;
  assign PCWrite = ~stall;
  assign Bubble  = hazard | Branch_taken;

  // No extra stall state: the load leaves ID/EX on the next edge, which
  // clears the hazard by itself after exactly one held cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCResult_1 <= 32'd0;
      Instr_1    <= NOP_WORD;
      Valid_1    <= 1'b0;
    end else if (Branch_taken) begin
      PCResult_1 <= 32'd0;
      Instr_1    <= NOP_WORD;
      Valid_1    <= 1'b0;
    end else if (!stall) begin
      PCResult_1 <= PCResult;
      Instr_1    <= Instr;
      Valid_1    <= 1'b1;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  // Saturates instead of wrapping so a long run never reads as a short one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (stall && (StallCount != {STALL_CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end
`endif

endmodule

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 Parameter NOP_WORD, default 32'h0000_0000, instruction word loaded on flush or reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 PCResult  input  32  PC+4 of the fetched instruction.
REQ-005 Instr  input  32  fetched instruction word.
REQ-006 IdEx_MemRead  input  1  MemRead_1 of the instruction currently in ID/EX.
REQ-007 IdEx_Rt  input  5  destination register of the instruction currently in ID/EX.
REQ-008 Branch_taken  input  1  redirect from the branch resolution stage; flushes IF/ID.
REQ-009 PCResult_1  output  32  registered PC+4 to decode.
REQ-010 Instr_1  output  32  registered instruction to decode.
REQ-011 Valid_1  output  1  IF/ID holds a live instruction.
REQ-012 PCWrite  output  1  PC register enable for fetch.
REQ-013 Bubble  output  1  decode SHALL zero all control inputs of ID/EX when high.
REQ-014 StallCount  output  16  stall-cycle counter; present only under IF_ID_STALL_CNT_EN.

Function
REQ-015 Hazard SHALL be combinational: Valid_1 & IdEx_MemRead & (IdEx_Rt != 0) & (IdEx_Rt == Instr_1[25:21] | IdEx_Rt == Instr_1[20:16]).
REQ-016 Flush (Branch_taken=1) SHALL load Instr_1=NOP_WORD, Valid_1=0, PCResult_1=0 at the next edge.
REQ-017 Stall (hazard=1, Branch_taken=0) SHALL hold PCResult_1, Instr_1 and Valid_1 unchanged.
REQ-018 Otherwise the block SHALL load PCResult, Instr and Valid_1=1 at each edge; latency one cycle.
REQ-019 Flush SHALL take priority over stall when both occur in the same cycle.
REQ-020 PCWrite SHALL be 0 exactly when hazard=1 and Branch_taken=0; otherwise 1.
REQ-021 Bubble SHALL equal hazard | Branch_taken.
REQ-022 An invalid entry (Valid_1=0) SHALL never raise hazard.
REQ-023 Register 0 as IdEx_Rt SHALL never raise hazard.
REQ-024 A load-use stall SHALL last one cycle, because the load leaves ID/EX on the next edge; the block SHALL NOT add extra stall state.

Reset
REQ-025 While rst_n=0: PCResult_1=0, Instr_1=NOP_WORD, Valid_1=0, StallCount=0, asynchronously.
REQ-026 During reset, PCWrite SHALL be 1 and Bubble SHALL be 0, since Valid_1=0 suppresses hazard.
REQ-027 Deassertion of rst_n SHALL take effect at the first clk edge after release.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-029 Macro IF_ID_STALL_CNT_EN defined: StallCount SHALL increment on every edge where hazard=1 and Branch_taken=0.
REQ-030 With the macro defined, StallCount SHALL saturate at 16'hFFFF.
REQ-031 Macro IF_ID_STALL_CNT_EN undefined: the StallCount port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared pipeline package SHALL hold NOP_WORD, the rs/rt field bit positions and the counter width constant.
REQ-033 Hazard detection SHALL be one sub-module, hazard_detect, containing only combinational logic.
REQ-034 The register and the counter SHALL live in if_id.

Verification
REQ-035 Reset then Instr=32'h012A4020, PCResult=32'h4 for 1 edge -> Instr_1=32'h012A4020, PCResult_1=4, Valid_1=1, PCWrite=1.
REQ-036 Instr_1 rs=9, IdEx_MemRead=1, IdEx_Rt=9 -> PCWrite=0, Bubble=1, outputs held 1 cycle, StallCount 0->1.
REQ-037 Same stall condition plus Branch_taken=1 -> next edge Instr_1=0, Valid_1=0, PCWrite=1, StallCount unchanged.
REQ-038 IdEx_Rt=0 with Instr_1 rs=0 and IdEx_MemRead=1 -> no stall; Bubble=0.
REQ-039 rst_n pulsed low mid-stall, asynchronous to clk -> outputs reset immediately; Valid_1=0 before the next edge.
REQ-040 Counter forced to 16'hFFFE, then 3 stall cycles -> StallCount=16'hFFFF and holds.
